stdcore_unpack: RTL
===================

STDCORE_UNPACK -- requirements
Module: stdcore_unpack

Interface
REQ-001 SHALL have parameter DW, default 8: width of one output sub-word.
REQ-002 SHALL have parameter RATIO, default 4: sub-words per input word; legal range 2..256.
REQ-003 SHALL have derived parameter SW, default CLOG2(RATIO): width of p_num and the internal index.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port arst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port p  input  RATIO*DW: wide input word, driven by the upstream async FIFO consumer port.
REQ-007 SHALL have port p_num  input  SW: number of valid sub-words in p, minus 1.
REQ-008 SHALL have port p_val  input  1: input word valid.
REQ-009 SHALL have port p_rdy  output  1: input word accepted when p_val && p_rdy.
REQ-010 SHALL have port c  output  DW: current sub-word.
REQ-011 SHALL have port c_last  output  1: c is the final valid sub-word of its input word.
REQ-012 SHALL have port c_val  output  1: c and c_last valid.
REQ-013 SHALL have port c_rdy  input  1: sub-word consumed when c_val && c_rdy.

Function
REQ-014 SHALL implement two states: EMPTY (no word held) and HOLD (word held, sub-words pending).
REQ-015 SHALL drive c_val = 1 exactly in HOLD.
REQ-016 SHALL drive p_rdy = (state==EMPTY) || (c_val && c_rdy && c_last); combinational, no dependence on p_val.
REQ-017 On input accept: latch p into the holding register, latch p_num into the limit register, set index to 0, enter or stay in HOLD.
REQ-018 Latency: word accepted at edge k SHALL present sub-word 0 with c_val=1 in the cycle after edge k.
REQ-019 c SHALL be sub-word[index] of the holding register; c_last = (index == limit).
REQ-020 On c_val && c_rdy && !c_last: increment index by 1; remain in HOLD.
REQ-021 On c_val && c_rdy && c_last without input accept: enter EMPTY; index returns to 0.
REQ-022 Last sub-word consumed and new word accepted in the same cycle: load the new word, index 0, stay in HOLD; no bubble; sustained throughput of one sub-word per clock.
REQ-023 c_val=1 && c_rdy=0: c, c_last and index SHALL hold stable; p_rdy=0.
REQ-024 p_num >= RATIO is illegal; behaviour undefined; flagged by a simulation-only assertion.
REQ-025 In EMPTY, c SHALL retain its last value; c_last SHALL be 0.

Reset
REQ-026 With arst_n low, the block SHALL asynchronously force: state EMPTY, c_val=0, c_last=0, index=0, limit=0, holding register=0, c=0, p_rdy=1.
REQ-027 Reset asserted mid-word SHALL discard all pending sub-words; the first word after release starts at sub-word 0.
REQ-028 Release of arst_n SHALL take effect at the first clk edge after release; no sync reset input.

Configuration
REQ-029 Macro STDCORE_UNPACK_MSB_FIRST_EN defined: sub-word i = p[(RATIO-i)*DW-1 -: DW], so the most significant sub-word is emitted first; valid sub-words are the top p_num+1.
REQ-030 Macro STDCORE_UNPACK_MSB_FIRST_EN undefined: sub-word i = p[(i+1)*DW-1 -: DW], so the least significant sub-word is emitted first; valid sub-words are the bottom p_num+1.

Verification (DW=8, RATIO=4, macro undefined unless stated)
REQ-031 p=0x44332211, p_num=3, c_rdy=1 -> c = 11,22,33,44 on 4 consecutive cycles; c_last only with 44; p_rdy=1 in the 44 cycle.
REQ-032 Back-to-back words 0x44332211 and 0x88776655 held valid, c_rdy=1 -> 8 sub-words 11..88 on 8 consecutive cycles, no gap.
REQ-033 p_num=1, p=0xDDCCBBAA -> c = AA then BB (c_last=1); CC and DD never appear.
REQ-034 c_rdy toggled 1,0,0,1,... on p=0x44332211 -> c holds 22 while stalled; p_rdy=0 throughout; no sub-word lost or duplicated.
REQ-035 arst_n pulsed low after 22 is consumed -> c_val=0 immediately; next word 0xA4A3A2A1 yields A1 first.
REQ-036 STDCORE_UNPACK_MSB_FIRST_EN defined, p=0x44332211, p_num=2 -> c = 44,33,22; c_last with 22.

Source files
------------

// File: rtl/stdcore_unpack.sv
// Wide-word to sub-word unpacker: holds one input word and streams its valid
// sub-words out one per cycle. Define STDCORE_UNPACK_MSB_FIRST_EN to emit the MSB sub-word first.
module stdcore_unpack #(
    parameter int DW    = 8,
    parameter int RATIO = 4,
    parameter int SW    = $clog2(RATIO)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [RATIO*DW-1:0] p,
    input  logic [SW-1:0]       p_num,
    input  logic                p_val,
    output logic                p_rdy,
    output logic [DW-1:0]       c,
    output logic                c_last,
    output logic                c_val,
    input  logic                c_rdy
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [SW-1:0]         index_reg, index_next;
    logic [SW-1:0]         limit_reg, limit_next;
    logic [RATIO*DW-1:0]   hold_reg,  hold_next;
    logic [DW-1:0]         c_reg,     c_next;

    logic [DW-1:0]         p_sub    [RATIO];
    logic [DW-1:0]         hold_sub [RATIO];
    logic [SW-1:0]         index_inc;
    logic                  accept;
    logic                  fire;

    // Sub-word i as seen by the consumer, for both the incoming and the held word
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_sub
`ifdef STDCORE_UNPACK_MSB_FIRST_EN
            assign p_sub[gi]    = p[(RATIO-gi)*DW-1 -: DW];
            assign hold_sub[gi] = hold_reg[(RATIO-gi)*DW-1 -: DW];
`else
            assign p_sub[gi]    = p[(gi+1)*DW-1 -: DW];
            assign hold_sub[gi] = hold_reg[(gi+1)*DW-1 -: DW];
`endif
        end
    endgenerate

    assign c_val     = (state_reg == HOLD);
    assign c_last    = c_val && (index_reg == limit_reg);
    assign c         = c_reg;
    assign fire      = c_val && c_rdy;
    assign p_rdy     = (state_reg == EMPTY) || (fire && c_last);
    assign accept    = p_val && p_rdy;
    assign index_inc = index_reg + SW'(1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= EMPTY;
            index_reg <= '0;
            limit_reg <= '0;
            hold_reg  <= '0;
            c_reg     <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            limit_reg <= limit_next;
            hold_reg  <= hold_next;
            c_reg     <= c_next;
        end
    end

    // c is registered so it keeps its last value once the block drains to EMPTY
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        limit_next = limit_reg;
        hold_next  = hold_reg;
        c_next     = c_reg;
        if (accept) begin
            state_next = HOLD;
            index_next = '0;
            limit_next = p_num;
            hold_next  = p;
            c_next     = p_sub[0];
        end else if (fire && c_last) begin
            state_next = EMPTY;
            index_next = '0;
        end else if (fire) begin
            index_next = index_inc;
            c_next     = hold_sub[index_inc];
        end
    end

`ifndef SYNTHESIS
    generate
        if (RATIO < (1 << SW)) begin : g_num_chk
            a_p_num_legal: assert property (@(posedge clk) disable iff (!arst_n)
                (p_val && p_rdy) |-> (int'(p_num) < RATIO));
        end
    endgenerate
`endif

endmodule
